// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM bridge
//
// Purpose : FSM state encoding and halfword-index constants used by
//           sram_ctrl and its testbench.
// Ports   : none (package).

package sram_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP_HI  = 3'd1,
      STROBE_HI = 3'd2,
      SETUP_LO  = 3'd3,
      STROBE_LO = 3'd4,
      ACK       = 3'd5
   } sram_state_t;

   // Halfword index appended to the word address: big-endian, so the
   // upper data half lives at the even SRAM address.
   localparam logic HALF_HI = 1'b0;
   localparam logic HALF_LO = 1'b1;

endpackage

// File: rtl/sram_strobe_timer.sv
// rtl/sram_strobe_timer.sv - loadable down-counter timing one SRAM strobe
//
// Purpose : Loaded with the wait count during a setup cycle, counts down
//           while enabled and flags the final strobe cycle.
// Ports   : i_clk      clock, rising edge
//           i_rst_n    asynchronous active-low reset
//           i_load     load i_load_val into the counter
//           i_load_val reload value (extra strobe cycles)
//           i_en       strobe in progress
//           o_done     high during the last strobe cycle

module sram_strobe_timer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_en,
   output logic       o_done
);

   logic [3:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Loaded with N, the strobe sees N..0, i.e. N+1 cycles.
   assign o_done = i_en && (r_cnt == 4'd0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - Wishbone classic responder bridging 32-bit to 16-bit async SRAM
//
// Purpose : Splits one 32-bit Wishbone access into up to two 16-bit SRAM
//           accesses (upper half first), each a setup cycle followed by
//           WAIT+1 strobe cycles, then a one-cycle acknowledge.
// Macro   : SRAM_CTRL_ERR_EN adds err_o; requests with no byte selected
//           (or outside the SRAM) then end in err_o instead of ack_o.
// Ports   : clk_i, rst_i          clock, asynchronous active-low reset
//           cyc_i, stb_i, we_i    Wishbone cycle, strobe, write enable
//           sel_i[3:0]            byte selects, bit 3 = dat[31:24]
//           adr_i[AWIDTH-1:0]     word address
//           dat_i[31:0]           write data
//           dat_o[31:0]           registered read data
//           ack_o                 one-cycle acknowledge
//           err_o                 one-cycle error (SRAM_CTRL_ERR_EN only)
//           sram_adr_o            halfword address {adr, hbit}
//           sram_dat_i/o, sram_dat_oe   split tristate data bus
//           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  strobes

module sram_ctrl
   import sram_pkg::*;
#(
   parameter int AWIDTH = 18,
   parameter int WAIT   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [3:0]        sel_i,
   input  logic [AWIDTH-1:0] adr_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   output logic              ack_o,
`ifdef SRAM_CTRL_ERR_EN
   output logic              err_o,
`endif
   output logic [AWIDTH:0]   sram_adr_o,
   input  logic [15:0]       sram_dat_i,
   output logic [15:0]       sram_dat_o,
   output logic              sram_dat_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   sram_state_t       r_state;
   sram_state_t       w_next;
   logic [AWIDTH-1:0] r_adr;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [31:0]       r_dat;
   logic [31:0]       r_dat_o;
   logic              r_abort;
   logic              w_accept;
   logic              w_stop;
   logic              w_load;
   logic              w_strobe;
   logic              w_active;
   logic              w_hbit;
   logic              w_done;
   logic [1:0]        w_half_sel;
`ifdef SRAM_CTRL_ERR_EN
   localparam logic [AWIDTH:0] SRAM_WORDS = (AWIDTH+1)'(1) << AWIDTH;
   logic              r_err;
   logic              w_req_err;

   assign w_req_err = (sel_i == 4'h0) || ({1'b0, adr_i} >= SRAM_WORDS);
`endif

   assign w_accept = (r_state == IDLE) && cyc_i && stb_i;
   // Once the initiator has dropped cyc_i, finish the strobe in flight but
   // do not start the other half.
   assign w_stop   = r_abort || !cyc_i;
   assign w_load   = (r_state == SETUP_HI) || (r_state == SETUP_LO);
   assign w_strobe = (r_state == STROBE_HI) || (r_state == STROBE_LO);
   assign w_active = w_load || w_strobe;
   assign w_hbit   = ((r_state == SETUP_LO) || (r_state == STROBE_LO)) ? HALF_LO : HALF_HI;

   sram_strobe_timer u_timer (
      .i_clk      (clk_i),
      .i_rst_n    (rst_i),
      .i_load     (w_load),
      .i_load_val (4'(WAIT)),
      .i_en       (w_strobe),
      .o_done     (w_done)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (cyc_i && stb_i) begin
`ifdef SRAM_CTRL_ERR_EN
               if (w_req_err)              w_next = ACK;
               else
`endif
               if (|sel_i[3:2])            w_next = SETUP_HI;
               else if (|sel_i[1:0])       w_next = SETUP_LO;
               else                        w_next = ACK;
            end
         end
         SETUP_HI:  w_next = STROBE_HI;
         STROBE_HI: begin
            if (w_done) begin
               if ((|r_sel[1:0]) && !w_stop) w_next = SETUP_LO;
               else                          w_next = ACK;
            end
         end
         SETUP_LO:  w_next = STROBE_LO;
         STROBE_LO: begin
            if (w_done) w_next = ACK;
         end
         ACK:       w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_sel   <= 4'h0;
         r_dat   <= 32'h0;
         r_dat_o <= 32'h0;
         r_abort <= 1'b0;
`ifdef SRAM_CTRL_ERR_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_adr   <= adr_i;
            r_we    <= we_i;
            r_sel   <= sel_i;
            r_dat   <= dat_i;
            r_dat_o <= 32'h0;
            r_abort <= 1'b0;
`ifdef SRAM_CTRL_ERR_EN
            r_err   <= w_req_err;
`endif
         end else if ((r_state != IDLE) && !cyc_i) begin
            r_abort <= 1'b1;
         end
         // Sample the SRAM at the edge that ends the final strobe cycle.
         if (w_done && !r_we) begin
            if (r_state == STROBE_HI) r_dat_o[31:16] <= sram_dat_i;
            else                      r_dat_o[15:0]  <= sram_dat_i;
         end
      end
   end

   assign w_half_sel  = (w_hbit == HALF_LO) ? r_sel[1:0] : r_sel[3:2];

   assign dat_o       = r_dat_o;
`ifdef SRAM_CTRL_ERR_EN
   assign ack_o       = (r_state == ACK) && !r_err;
   assign err_o       = (r_state == ACK) && r_err;
`else
   assign ack_o       = (r_state == ACK);
`endif
   assign sram_adr_o  = {r_adr, w_hbit};
   assign sram_dat_o  = (w_hbit == HALF_LO) ? r_dat[15:0] : r_dat[31:16];
   // Data is driven only for writes, and oe_n only falls on reads, so the
   // two never overlap.
   assign sram_dat_oe = w_active && r_we;
   assign sram_ce_n   = !w_strobe;
   assign sram_oe_n   = !(w_strobe && !r_we);
   assign sram_we_n   = !(w_strobe && r_we);
   assign sram_ub_n   = !(w_active && w_half_sel[1]);
   assign sram_lb_n   = !(w_active && w_half_sel[0]);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with SRAM and word-level reference models

module tb_sram_ctrl;

   localparam int AW     = 18;
   localparam int WAIT_P = 2;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          cyc_i = 1'b0;
   logic          stb_i = 1'b0;
   logic          we_i  = 1'b0;
   logic [3:0]    sel_i = 4'h0;
   logic [AW-1:0] adr_i = '0;
   logic [31:0]   dat_i = 32'h0;
   logic [31:0]   dat_o;
   logic          ack_o;
`ifdef SRAM_CTRL_ERR_EN
   logic          err_o;
`endif
   logic [AW:0]   sram_adr_o;
   logic [15:0]   sram_dat_i = 16'hDEAD;
   logic [15:0]   sram_dat_o;
   logic          sram_dat_oe;
   logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   sram_ctrl #(.AWIDTH(AW), .WAIT(WAIT_P)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cyc_i       (cyc_i),
      .stb_i       (stb_i),
      .we_i        (we_i),
      .sel_i       (sel_i),
      .adr_i       (adr_i),
      .dat_i       (dat_i),
      .dat_o       (dat_o),
      .ack_o       (ack_o),
`ifdef SRAM_CTRL_ERR_EN
      .err_o       (err_o),
`endif
      .sram_adr_o  (sram_adr_o),
      .sram_dat_i  (sram_dat_i),
      .sram_dat_o  (sram_dat_o),
      .sram_dat_oe (sram_dat_oe),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_ub_n   (sram_ub_n),
      .sram_lb_n   (sram_lb_n)
   );

   always #5 clk_i = ~clk_i;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Physical SRAM model (16-bit halfwords) and word-level reference model.
   bit [15:0] smem [int];
   bit [31:0] rmem [int];

   function automatic bit [15:0] init_half(input int a);
      return 16'(a * 40503) ^ 16'h5A5A;
   endfunction

   function automatic bit [15:0] sram_rd(input int a);
      if (smem.exists(a)) return smem[a];
      return init_half(a);
   endfunction

   function automatic bit [31:0] ref_rd(input int w);
      if (rmem.exists(w)) return rmem[w];
      return {init_half(2*w), init_half(2*w+1)};
   endfunction

   function automatic void ref_wr(input int w, input bit [3:0] sel, input bit [31:0] d);
      bit [31:0] cur;
      cur = ref_rd(w);
      for (int b = 0; b < 4; b++)
         if (sel[b]) cur[8*b +: 8] = d[8*b +: 8];
      rmem[w] = cur;
   endfunction

   // Bus monitor: samples on the falling edge, mid-cycle.
   int         strobe_cyc = 0;
   int         we_cyc     = 0;
   int         ack_total  = 0;
   logic       prev_ce_n  = 1'b1;
   logic       prev_ack   = 1'b0;
   logic       last_ub_n  = 1'b1;
   logic       last_lb_n  = 1'b1;
   logic [AW:0] addr_q [$];

   always @(negedge clk_i) begin
      if (rst_i) begin
         if (!sram_ce_n) begin
            strobe_cyc++;
            last_ub_n = sram_ub_n;
            last_lb_n = sram_lb_n;
            if (prev_ce_n) addr_q.push_back(sram_adr_o);
            if (!sram_we_n) begin
               bit [15:0] cur;
               we_cyc++;
               cur = sram_rd(int'(sram_adr_o));
               if (!sram_ub_n) cur[15:8] = sram_dat_o[15:8];
               if (!sram_lb_n) cur[7:0]  = sram_dat_o[7:0];
               smem[int'(sram_adr_o)] = cur;
            end
         end
         if (ack_o) begin
            ack_total++;
            chk("ack_width", prev_ack, 1'b0);
         end
         if (sram_dat_oe || !sram_oe_n)
            chk("oe_conflict", sram_dat_oe & ~sram_oe_n, 1'b0);
      end
      prev_ce_n  = sram_ce_n;
      prev_ack   = ack_o;
      sram_dat_i = (!sram_ce_n && !sram_oe_n) ? sram_rd(int'(sram_adr_o)) : 16'hDEAD;
   end

   // One Wishbone transaction. Entered #1 after a rising edge with the DUT
   // in IDLE, or in ACK when from_ack is set (back-to-back).
   task automatic txn(input bit we, input bit [3:0] sel, input int adr,
                      input bit [31:0] dat, input bit from_ack, input bit keep);
      int         sc0, wc0, lat, halves, exp_lat;
      bit [31:0]  word, exp_rd;
      logic       done;
      logic [AW:0] exp_q [$];
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = AW'(adr); dat_i = dat;
      if (from_ack) begin
         @(posedge clk_i); #1;
         chk("ack_one_cycle", ack_o, 1'b0);
      end
      addr_q.delete();
      sc0 = strobe_cyc;
      wc0 = we_cyc;
      halves = int'(|sel[3:2]) + int'(|sel[1:0]);
      exp_lat = (halves == 2) ? 2*WAIT_P + 5 : (halves == 1) ? WAIT_P + 3 : 1;
      if (|sel[3:2]) exp_q.push_back({AW'(adr), 1'b0});
      if (|sel[1:0]) exp_q.push_back({AW'(adr), 1'b1});
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk_i); #1;
`ifdef SRAM_CTRL_ERR_EN
         done = ack_o | err_o;
`else
         done = ack_o;
`endif
         if (done) begin
            lat = c;
            break;
         end
      end
      chk("latency", lat, exp_lat);
`ifdef SRAM_CTRL_ERR_EN
      chk("err_flag", err_o, (sel == 4'h0));
      chk("ack_flag", ack_o, (sel != 4'h0));
`endif
      chk("strobe_cycles", strobe_cyc - sc0, halves * (WAIT_P + 1));
      chk("we_cycles", we_cyc - wc0, we ? halves * (WAIT_P + 1) : 0);
      chk("access_count", addr_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         if (k < addr_q.size()) chk("sram_adr", addr_q[k], exp_q[k]);
      word = ref_rd(adr);
      if (we) begin
         ref_wr(adr, sel, dat);
      end else begin
         exp_rd = 32'h0;
         if (|sel[3:2]) exp_rd[31:16] = word[31:16];
         if (|sel[1:0]) exp_rd[15:0]  = word[15:0];
         chk("read_data", dat_o, exp_rd);
      end
      if (!keep) begin
         cyc_i = 1'b0; stb_i = 1'b0;
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      bit        keep, prev_keep;
      bit [15:0] saved;
      int        acks0, sc0, lat;

      // Reset state.
      #1;
      chk("rst_ack", ack_o, 1'b0);
      chk("rst_dat_o", dat_o, 32'h0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
      chk("rst_dat_oe", sram_dat_oe, 1'b0);
      chk("rst_adr", sram_adr_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Two-half read at 0x100 returning 0x1234 then 0xABCD.
      smem[32'h200] = 16'h1234;
      smem[32'h201] = 16'hABCD;
      rmem[32'h100] = 32'h1234ABCD;
      txn(1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0);
      chk("req33_dat", dat_o, 32'h1234ABCD);

      // Lower-half-only write; upper half must stay untouched.
      saved = sram_rd(32'h40);
      txn(1'b1, 4'h3, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("req34_lo", sram_rd(32'h41), 16'hBEEF);
      chk("req34_hi_kept", sram_rd(32'h40), saved);

      // Single-byte write to the top byte.
      saved = sram_rd(32'h42);
      txn(1'b1, 4'h8, 32'h21, 32'h11000000, 1'b0, 1'b0);
      chk("req35_ub_n", last_ub_n, 1'b0);
      chk("req35_lb_n", last_lb_n, 1'b1);
      chk("req35_byte", sram_rd(32'h42), {8'h11, saved[7:0]});

      // No byte selected.
      txn(1'b0, 4'h0, 32'h22, 32'h0, 1'b0, 1'b0);

      // Reset during the lower-half write strobe.
      acks0 = ack_total;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = AW'(32'h80); dat_i = 32'hCAFEF00D;
      repeat (WAIT_P + 4) @(posedge clk_i);
      #1;
      chk("pre_rst_we_n", sram_we_n, 1'b0);
      #2 rst_i = 1'b0;
      #1;
      chk("midrst_ce_we", {sram_ce_n, sram_we_n}, 2'b11);
      chk("midrst_dat_oe", sram_dat_oe, 1'b0);
      chk("midrst_adr", sram_adr_o, 0);
      cyc_i = 1'b0; stb_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("midrst_no_ack", ack_total - acks0, 0);
      // The upper-half write finished before reset; the lower half never strobed.
      ref_wr(32'h80, 4'hC, 32'hCAFEF00D);
      txn(1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 1'b0);

      // Initiator abandons the cycle during the upper strobe.
      sc0 = strobe_cyc;
      addr_q.delete();
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = AW'(32'h5);
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk_i); #1;
         if (c == 3) begin
            cyc_i = 1'b0; stb_i = 1'b0;
         end
         if (ack_o) begin
            lat = c;
            break;
         end
      end
      chk("drop_latency", lat, WAIT_P + 3);
      chk("drop_strobes", strobe_cyc - sc0, WAIT_P + 1);
      chk("drop_accesses", addr_q.size(), 1);
      @(posedge clk_i); #1;

      // Back-to-back reads with stb_i held through ACK.
      txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b1);
      txn(1'b0, 4'hF, 32'h11, 32'h0, 1'b1, 1'b1);
      txn(1'b0, 4'h3, 32'h12, 32'h0, 1'b1, 1'b0);

      // Randomized traffic against the reference model.
      prev_keep = 1'b0;
      for (int i = 0; i < 40; i++) begin
         keep = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
         txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
             $urandom, prev_keep, keep);
         prev_keep = keep;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 18, meaning the bus word-address width; the SRAM halfword address is AWIDTH+1 bits.
REQ-002 SHALL have parameter WAIT, default 2, meaning extra strobe cycles per SRAM access (0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  asynchronous active-low reset.
REQ-006 cyc_i, stb_i  in  1 each  Wishbone classic cycle/strobe.
REQ-007 we_i  in  1  write enable.
REQ-008 sel_i  in  4  byte selects; bit 3 = dat[31:24].
REQ-009 adr_i  in  AWIDTH  word address.
REQ-010 dat_i  in  32  write data.
REQ-011 dat_o  out  32  read data, registered.
REQ-012 ack_o  out  1  single-cycle acknowledge.
REQ-013 sram_adr_o  out  AWIDTH+1  halfword address {adr_i, hbit}.
REQ-014 sram_dat_i  in  16, sram_dat_o  out  16, sram_dat_oe  out  1  tristate data bus pieces.
REQ-015 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Function
REQ-016 SHALL be the responder for the core's Wishbone initiators, bridging one 32-bit access into up to two 16-bit async-SRAM accesses.
REQ-017 Big-endian: hbit=0 carries dat[31:16] with sel[3:2]; hbit=1 carries dat[15:0] with sel[1:0]; ub_n tracks the upper sel bit of the half.
REQ-018 FSM states IDLE, SETUP_HI, STROBE_HI, SETUP_LO, STROBE_LO, ACK.
REQ-019 IDLE: on cyc_i&stb_i latch adr/we/sel/dat, go to SETUP_HI if sel[3:2]!=0, else SETUP_LO if sel[1:0]!=0, else ACK.
REQ-020 SETUP_x: 1 cycle; address, ub_n/lb_n, sram_dat_oe (writes) valid; ce_n, oe_n, we_n high.
REQ-021 STROBE_x: exactly WAIT+1 cycles; ce_n low, plus oe_n low (read) or we_n low (write); counter reloads on entry.
REQ-022 After STROBE_HI go to SETUP_LO if sel[1:0]!=0, else ACK; after STROBE_LO go to ACK.
REQ-023 Read data SHALL be captured from sram_dat_i on the clock edge ending the last strobe cycle; unselected halves of dat_o read as 0.
REQ-024 ACK: ack_o=1 for exactly one cycle, then IDLE; IDLE SHALL accept a new request on the following cycle with no forced gap.
REQ-025 Latency, cycle 0 = request cycle in IDLE: both halves -> ack in cycle 2*WAIT+5; one half -> cycle WAIT+3.
REQ-026 If cyc_i drops mid-transaction, the current SRAM strobe SHALL complete; ack_o is still issued; no extra access starts.
REQ-027 sram_dat_oe SHALL never be high while oe_n is low.

Reset
REQ-028 While rst_i low: state IDLE, ack_o 0, dat_o 0, all *_n outputs 1, sram_dat_oe 0, sram_adr_o 0, counter 0; this applies immediately, including mid-strobe.

Configuration
REQ-029 Macro SRAM_CTRL_ERR_EN: when defined, port err_o (out, 1) exists; a request with sel_i==0 or adr_i beyond the SRAM size yields err_o=1 for one cycle instead of ack_o, with no SRAM strobe.
REQ-030 Without SRAM_CTRL_ERR_EN: no err_o port; sel_i==0 acks in cycle 1 with no SRAM strobe.

Structure
REQ-031 Shared package sram_pkg SHALL hold the FSM state enum and the halfword-index constants HALF_HI=0 and HALF_LO=1.
REQ-032 One sub-module, sram_strobe_timer: a loadable down-counter producing a done pulse; no other hierarchy.

Verification
REQ-033 WAIT=2, read adr 0x100, sel 0xF, SRAM model returns 0x1234 then 0xABCD -> sram_adr_o 0x200 then 0x201; dat_o 0x1234ABCD; ack in cycle 9.
REQ-034 Write dat 0xDEADBEEF, sel 0x3 -> only hbit=1 access, sram_dat_o 0xBEEF, we_n low 3 cycles; ack in cycle 5; upper half untouched.
REQ-035 Write sel 0x8, dat 0x11000000 -> one access, ub_n=0, lb_n=1, sram_dat_o[15:8]=0x11.
REQ-036 Assert rst_i low during STROBE_LO of a write -> we_n and ce_n high in the same cycle; ack_o never pulses; the next request completes normally.
REQ-037 Back-to-back reads with stb_i held high across ack -> second access starts the cycle after ACK; both acks one cycle wide.
REQ-038 With SRAM_CTRL_ERR_EN, sel 0x0 -> err_o 1 in cycle 1, ack_o 0, ce_n stays high; without it -> ack_o 1 in cycle 1.
